// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the quadrature motor position controller.
package motor_ctrl_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_SETTLE, ST_FAULT} state_t;

   typedef enum logic [1:0] {
      FLT_NONE    = 2'b00,
      FLT_STALL   = 2'b01,
      FLT_ILLEGAL = 2'b10
   } fault_t;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   // Position of an {A,B} pair along the forward Gray cycle 00->10->11->01.
   function automatic logic [1:0] quad_phase(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'd0;
         2'b10:   return 2'd1;
         2'b11:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/quad_decoder.sv
// Synchronises the asynchronous A/B pins and classifies each sampled transition
// as a forward step, a reverse step or an illegal double-bit change.
module quad_decoder
   import motor_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enc_a,
   input  logic enc_b,
   output logic inc,
   output logic dec,
   output logic illegal
);

   logic [SYNC_STAGES-1:0][1:0] sync;
   logic [1:0]                  prev;
   logic [1:0]                  cur;
   logic [1:0]                  step;

   assign cur = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         prev <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], {enc_a, enc_b}};
         prev <= cur;
      end
   end

   // Phase distance mod 4: 1 forward, 3 reverse, 2 means both bits flipped.
   always_comb begin
      step    = quad_phase(cur) - quad_phase(prev);
      inc     = (step == 2'd1);
      dec     = (step == 2'd3);
      illegal = (step == 2'd2);
   end

endmodule

// File: rtl/motor_position_controller.sv
// Closed-loop position sequencer: decodes the encoder, drives the motor toward a
// commanded target, settles, reports done, and latches stall/illegal-edge faults.
module motor_position_controller
   import motor_ctrl_pkg::*;
#(
   parameter int unsigned POS_W         = 16,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STALL_CYCLES  = 400_000,
   parameter int unsigned SETTLE_CYCLES = 1_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [POS_W-1:0] cmd_target,
   input  logic             abort,
   input  logic             pos_clear,
   input  logic             clear_fault,
   input  logic             enc_a,
   input  logic             enc_b,
   output logic             motor_en,
   output logic             motor_dir,
   output logic [POS_W-1:0] position,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [1:0]       fault_code
);

   localparam int unsigned STALL_W  = $clog2(STALL_CYCLES + 1);
   localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

   state_t               state;
   fault_t               fcode;
   logic [POS_W-1:0]     target;
   logic [POS_W-1:0]     diff;
   logic [POS_W-1:0]     diff_new;
   logic [STALL_W-1:0]   stall_cnt;
   logic [SETTLE_W-1:0]  settle_cnt;
   logic                 inc, dec, illegal;
   logic                 accept, clear_now, at_target, enc_edge;

   quad_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_decoder (
      .clk     (clk),
      .rst_n   (rst_n),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .inc     (inc),
      .dec     (dec),
      .illegal (illegal)
   );

   assign cmd_ready  = (state == ST_IDLE) && !abort;
   assign accept     = cmd_valid && cmd_ready;
   assign clear_now  = pos_clear && (state == ST_IDLE);
   assign at_target  = (position == target);
   assign enc_edge   = inc || dec;
   assign diff       = target - position;
   // A same-cycle clear takes precedence, so the new command is judged from zero.
   assign diff_new   = cmd_target - (clear_now ? '0 : position);
   assign busy       = (state != ST_IDLE);
   assign fault      = (state == ST_FAULT);
   assign fault_code = fcode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         position <= '0;
      else if (clear_now) position <= '0;
      else if (inc)       position <= position + POS_W'(1);
      else if (dec)       position <= position - POS_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         fcode      <= FLT_NONE;
         target     <= '0;
         stall_cnt  <= '0;
         settle_cnt <= '0;
         motor_en   <= 1'b0;
         motor_dir  <= DIR_CW;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (illegal) begin
            state    <= ST_FAULT;
            fcode    <= FLT_ILLEGAL;
            motor_en <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     target <= cmd_target;
                     if (diff_new == '0) begin
                        done <= 1'b1;
                     end else begin
                        state     <= ST_MOVE;
                        motor_en  <= 1'b1;
                        motor_dir <= diff_new[POS_W-1];
                        stall_cnt <= '0;
                     end
                  end
               end
               ST_MOVE: begin
                  if (abort) begin
                     state    <= ST_IDLE;
                     motor_en <= 1'b0;
                  end else if (at_target) begin
                     state      <= ST_SETTLE;
                     motor_en   <= 1'b0;
                     settle_cnt <= '0;
                  end else if (!enc_edge && stall_cnt == STALL_W'(STALL_CYCLES - 1)) begin
                     state    <= ST_FAULT;
                     fcode    <= FLT_STALL;
                     motor_en <= 1'b0;
                  end else begin
                     motor_dir <= diff[POS_W-1];
                     stall_cnt <= enc_edge ? '0 : stall_cnt + STALL_W'(1);
                  end
               end
               ST_SETTLE: begin
                  if (abort) begin
                     state <= ST_IDLE;
                  end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                     if (at_target) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                     end else begin
                        state     <= ST_MOVE;
                        motor_en  <= 1'b1;
                        motor_dir <= diff[POS_W-1];
                        stall_cnt <= '0;
                     end
                  end else begin
                     settle_cnt <= settle_cnt + SETTLE_W'(1);
                  end
               end
               ST_FAULT: begin
                  if (clear_fault) begin
                     state <= ST_IDLE;
                     fcode <= FLT_NONE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_motor_position_controller.sv
// Self-checking bench: encoder model follows motor_en/motor_dir, a scoreboard
// tracks every position step, and table vectors plus sequences cover corners.
module tb_motor_position_controller;

   localparam int POS_W = 16;
   localparam int SYNC  = 2;
   localparam int STALL = 500;
   localparam int SETTLE = 50;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [POS_W-1:0] cmd_target = '0;
   logic             abort = 1'b0;
   logic             pos_clear = 1'b0;
   logic             clear_fault = 1'b0;
   logic             enc_a = 1'b0;
   logic             enc_b = 1'b0;
   logic             motor_en;
   logic             motor_dir;
   logic [POS_W-1:0] position;
   logic             busy;
   logic             done;
   logic             fault;
   logic [1:0]       fault_code;

   motor_position_controller #(
      .POS_W(POS_W), .SYNC_STAGES(SYNC), .STALL_CYCLES(STALL), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_target(cmd_target), .abort(abort), .pos_clear(pos_clear),
      .clear_fault(clear_fault), .enc_a(enc_a), .enc_b(enc_b),
      .motor_en(motor_en), .motor_dir(motor_dir), .position(position),
      .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [1:0]       model_idx = 2'd0;
   logic [POS_W-1:0] model_pos = '0;
   logic             model_on = 1'b0;
   logic             sb_on = 1'b0;
   logic [POS_W-1:0] last_pos = '0;
   logic [POS_W-1:0] exp_q[$];

   function automatic logic [1:0] ab_of(input logic [1:0] idx);
      case (idx)
         2'd0:    return 2'b00;
         2'd1:    return 2'b10;
         2'd2:    return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Encoder model: one quadrature step every 20 clocks while the motor is enabled.
   initial begin
      forever begin
         repeat (20) @(negedge clk);
         if (model_on && motor_en && rst_n) begin
            if (motor_dir == 1'b0) begin
               model_idx = model_idx + 2'd1;
               model_pos = model_pos + 16'd1;
            end else begin
               model_idx = model_idx - 2'd1;
               model_pos = model_pos - 16'd1;
            end
            {enc_a, enc_b} = ab_of(model_idx);
            if (sb_on) exp_q.push_back(model_pos);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (sb_on && position !== last_pos) begin
            if (exp_q.size() == 0) check("sb_unexpected_step", {16'd0, position}, {16'd0, last_pos});
            else check("sb_position", {16'd0, position}, {16'd0, exp_q.pop_front()});
            last_pos = position;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_cmd(input logic [POS_W-1:0] t);
      @(negedge clk);
      cmd_target = t;
      cmd_valid  = 1'b1;
      #1;
      check("cmd_ready_at_offer", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic resync_sb();
      exp_q.delete();
      model_pos = position;
      last_pos  = position;
      sb_on     = 1'b1;
   endtask

   typedef struct {
      logic [POS_W-1:0] target;
      logic             exp_move;
      logic             exp_dir;
      logic [POS_W-1:0] exp_pos;
   } vec_t;

   vec_t vecs[4];
   int   dcount;
   int   cyc;

   initial begin
      vecs[0] = '{16'd40,   1'b1, 1'b0, 16'd40};
      vecs[1] = '{16'hFFF8, 1'b1, 1'b1, 16'hFFF8};
      vecs[2] = '{16'hFFF8, 1'b0, 1'b0, 16'hFFF8};
      vecs[3] = '{16'd5,    1'b1, 1'b0, 16'd5};

      #2;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_outputs", {26'd0, motor_en, motor_dir, busy, done, fault, 1'b0},
            32'd0);
      check("rst_position", {16'd0, position}, 32'd0);
      check("rst_fault_code", {30'd0, fault_code}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_on = 1'b1;
      resync_sb();

      for (int v = 0; v < 4; v++) begin
         send_cmd(vecs[v].target);
         if (!vecs[v].exp_move) begin
            check("same_target_done", {31'd0, done}, 32'd1);
            check("same_target_motor_en", {31'd0, motor_en}, 32'd0);
            check("same_target_busy", {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            check("same_target_done_width", {31'd0, done}, 32'd0);
         end else begin
            check("move_motor_en", {31'd0, motor_en}, 32'd1);
            check("move_motor_dir", {31'd0, motor_dir}, {31'd0, vecs[v].exp_dir});
            dcount = 0;
            for (int i = 0; i < 4000; i++) begin
               @(posedge clk); #1;
               if (done) dcount++;
               if (!busy) break;
            end
            repeat (5) begin
               @(posedge clk); #1;
               if (done) dcount++;
            end
            check("move_done_count", dcount, 32'd1);
            check("move_final_position", {16'd0, position}, {16'd0, vecs[v].exp_pos});
            check("move_idle", {30'd0, busy, motor_en}, 32'd0);
         end
      end

      // Stall: encoder held static while in MOVE.
      model_on = 1'b0;
      send_cmd(16'd100);
      cyc = 0;
      for (int i = 1; i <= STALL + 100; i++) begin
         @(posedge clk); #1;
         if (fault) begin cyc = i; break; end
      end
      check("stall_cycle", cyc, STALL);
      check("stall_code", {30'd0, fault_code}, 32'd1);
      check("stall_motor_off", {30'd0, motor_en, cmd_ready}, 32'd0);
      @(negedge clk); abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      check("abort_in_fault", {30'd0, fault, busy}, 32'd3);
      @(negedge clk); clear_fault = 1'b1;
      @(posedge clk); #1; clear_fault = 1'b0;
      check("stall_clear", {29'd0, busy, cmd_ready, fault}, 32'd2);
      check("stall_clear_code", {30'd0, fault_code}, 32'd0);

      // Illegal transition from IDLE.
      @(negedge clk);
      model_idx = model_idx + 2'd2;
      {enc_a, enc_b} = ab_of(model_idx);
      cyc = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (fault) begin cyc = i; break; end
      end
      check("illegal_idle_latency_ok", {31'd0, (cyc >= 1 && cyc <= SYNC + 2)}, 32'd1);
      check("illegal_idle_code", {30'd0, fault_code}, 32'd2);
      @(negedge clk); clear_fault = 1'b1;
      @(posedge clk); #1; clear_fault = 1'b0;
      check("illegal_idle_clear", {30'd0, fault, cmd_ready}, 32'd1);

      // Illegal transition during MOVE.
      model_on = 1'b1;
      resync_sb();
      send_cmd(position + 16'd50);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (position == 16'd8) break;
      end
      model_on = 1'b0;
      repeat (25) @(negedge clk);
      check("illegal_move_busy", {30'd0, busy, motor_en}, 32'd3);
      model_idx = model_idx + 2'd2;
      {enc_a, enc_b} = ab_of(model_idx);
      cyc = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (fault) begin cyc = i; break; end
      end
      check("illegal_move_latency_ok", {31'd0, (cyc >= 1 && cyc <= SYNC + 2)}, 32'd1);
      check("illegal_move_code", {30'd0, fault_code}, 32'd2);
      check("illegal_move_motor_off", {31'd0, motor_en}, 32'd0);
      @(negedge clk); clear_fault = 1'b1;
      @(posedge clk); #1; clear_fault = 1'b0;

      // pos_clear together with an accepted command: clear wins, target 0 is reached.
      sb_on = 1'b0;
      check("pre_clear_position", {16'd0, position}, 32'd8);
      @(negedge clk);
      pos_clear = 1'b1; cmd_valid = 1'b1; cmd_target = 16'd0;
      @(posedge clk); #1;
      pos_clear = 1'b0; cmd_valid = 1'b0;
      check("clear_cmd_position", {16'd0, position}, 32'd0);
      check("clear_cmd_done", {29'd0, done, busy, motor_en}, 32'd4);

      // abort while IDLE blocks the handshake.
      @(negedge clk);
      abort = 1'b1; cmd_valid = 1'b1; cmd_target = 16'd3;
      #1;
      check("abort_idle_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      abort = 1'b0; cmd_valid = 1'b0;
      check("abort_idle_no_accept", {30'd0, busy, done}, 32'd0);

      // abort mid-move at position 15.
      model_on = 1'b1;
      resync_sb();
      send_cmd(16'd40);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (position == 16'd15) break;
      end
      check("abort_reach_15", {16'd0, position}, 32'd15);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_motor_off", {30'd0, motor_en, busy}, 32'd0);
      dcount = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (done || motor_en) dcount++;
      end
      check("abort_no_done", dcount, 32'd0);

      // Asynchronous reset in the middle of a move.
      send_cmd(16'd60);
      repeat (100) @(negedge clk);
      check("pre_reset_moving", {30'd0, busy, motor_en}, 32'd3);
      sb_on = 1'b0;
      model_on = 1'b0;
      #2;
      rst_n = 1'b0;
      model_idx = 2'd0;
      {enc_a, enc_b} = 2'b00;
      #1;
      check("async_rst_position", {16'd0, position}, 32'd0);
      check("async_rst_outputs", {26'd0, motor_en, motor_dir, busy, done, fault, cmd_ready},
            32'd1);
      check("async_rst_code", {30'd0, fault_code}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_idle", {14'd0, position, busy, cmd_ready}, 32'd1);
      check("sb_queue_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
